pulse_burst_scheduler: RTL and testbench

//   Shares one programmable pulse-train generator between NCH requesters.
//   A round-robin arbiter grants the generator to one channel at a time.
//   The granted burst emits burst_len pulses: each pulse is high_w cycles high, then low_w cycles low.

---
 rtl/pulse_burst_scheduler.sv | 157 +++++++++++++++
 tb/tb_pulse_burst_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_scheduler.sv
// Shared pulse-train generator: a round-robin arbiter hands it to one requester at a time,
// and the owner receives burst_len pulses of high_w cycles high and low_w cycles low.
module pulse_burst_scheduler #(
    parameter int NCH = 2,
    parameter int CW  = 4,
    parameter int WW  = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  burst_len,
    input  logic [WW-1:0]  high_w,
    input  logic [WW-1:0]  low_w,
    output logic [NCH-1:0] grant,
    output logic           busy,
    output logic           pulse,
    output logic [NCH-1:0] done
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] grant_q, grant_d;
    logic           pulse_q, pulse_d;
    logic [PW-1:0]  rr_q, rr_d;
    logic [PW-1:0]  own_q, own_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]  ph_q, ph_d;
    logic [WW-1:0]  hw_q, hw_d;
    logic [WW-1:0]  lw_q, lw_d;

    logic           win_found;
    logic [PW-1:0]  win_idx;

    // A programmed width of zero still produces a one-cycle phase.
    function automatic logic [WW-1:0] eff_w(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] x);
        return (x == {WW{1'b1}}) ? x : x + WW'(1);
    endfunction

    // Round-robin search starting at rr_q, wrapping modulo NCH.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_q) + i) % NCH;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pulse_d = pulse_q;
        rr_d    = rr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        hw_d    = hw_q;
        lw_d    = lw_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    own_d   = win_idx;
                    grant_d = NCH'(1) << win_idx;
                    hw_d    = high_w;
                    lw_d    = low_w;
                    cnt_d   = burst_len;
                    ph_d    = WW'(1);
                    if (burst_len == '0) begin
                        state_d = DONE;
                        pulse_d = 1'b0;
                    end else begin
                        state_d = HIGH;
                        pulse_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (ph_q >= eff_w(hw_q)) begin
                    state_d = LOW;
                    pulse_d = 1'b0;
                    ph_d    = WW'(1);
                    cnt_d   = cnt_q - CW'(1);
                end else begin
                    ph_d = sat_inc(ph_q);
                end
            end
            LOW: begin
                if (ph_q >= eff_w(lw_q)) begin
                    ph_d = WW'(1);
                    if (cnt_q != '0) begin
                        state_d = HIGH;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    ph_d = sat_inc(ph_q);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ph_d    = '0;
                rr_d    = PW'((int'(own_q) + 1) % NCH);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            pulse_q <= 1'b0;
            rr_q    <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            hw_q    <= '0;
            lw_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            hw_q    <= hw_d;
            lw_q    <= lw_d;
        end
    end

    assign grant = grant_q;
    assign pulse = pulse_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE) ? grant_q : '0;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed bench for pulse_burst_scheduler (NCH=2, CW=4, WW=3).
module tb_pulse_burst_scheduler;

    logic       clock;
    logic       reset;
    logic [1:0] req;
    logic [3:0] burst_len;
    logic [2:0] high_w;
    logic [2:0] low_w;
    logic [1:0] grant;
    logic       busy;
    logic       pulse;
    logic [1:0] done;

    int n_chk  = 0;
    int n_fail = 0;

    pulse_burst_scheduler #(.NCH(2), .CW(4), .WW(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .burst_len(burst_len),
        .high_w   (high_w),
        .low_w    (low_w),
        .grant    (grant),
        .busy     (busy),
        .pulse    (pulse),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", grant); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_chk++;
        if (pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", pulse); end
        n_chk++;
        if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done got=%b exp=00", done); end
    endtask

    task automatic test_basic_burst();
        logic [8:0] pat;
        pat = 9'b110110110;
        do_reset();
        burst_len = 4'd3; high_w = 3'd2; low_w = 3'd1; req = 2'b01;
        tick();
        n_chk++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL basic_grant got=%b exp=01", grant); end
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (pulse !== pat[8-i]) begin
                n_fail++; $display("FAIL basic_pulse[%0d] got=%b exp=%b", i, pulse, pat[8-i]);
            end
            tick();
        end
        n_chk++;
        if (done !== 2'b01) begin n_fail++; $display("FAIL basic_done got=%b exp=01", done); end
        n_chk++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_done_grant got=%b/%b exp=01/1", grant, busy);
        end
        req = 2'b00;
        tick();
        n_chk++;
        if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle got g=%b d=%b b=%b exp 00/00/0", grant, done, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expd;
        int         cyc;
        do_reset();
        burst_len = 4'd1; high_w = 3'd1; low_w = 3'd1; req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            expd = (n % 2 == 0) ? 2'b01 : 2'b10;
            cyc  = 0;
            tick();
            while (done === 2'b00 && cyc < 20) begin
                tick();
                cyc++;
            end
            n_chk++;
            if (done !== expd) begin
                n_fail++; $display("FAIL rr_done[%0d] got=%b exp=%b", n, done, expd);
            end
            n_chk++;
            if (grant !== expd) begin
                n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", n, grant, expd);
            end
            tick();
        end
        req = 2'b00;
    endtask

    task automatic test_zero_len();
        do_reset();
        burst_len = 4'd0; high_w = 3'd2; low_w = 3'd2; req = 2'b10;
        tick();
        n_chk++;
        if (grant !== 2'b10 || done !== 2'b10) begin
            n_fail++; $display("FAIL zero_done got g=%b d=%b exp 10/10", grant, done);
        end
        n_chk++;
        if (pulse !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_pulse got p=%b b=%b exp 0/1", pulse, busy);
        end
        req = 2'b00;
        tick();
        n_chk++;
        if (grant !== 2'b00 || done !== 2'b00 || pulse !== 1'b0) begin
            n_fail++; $display("FAIL zero_idle got g=%b d=%b p=%b exp 00/00/0", grant, done, pulse);
        end
    endtask

    task automatic test_zero_widths();
        logic [3:0] pat;
        pat = 4'b1010;
        do_reset();
        burst_len = 4'd2; high_w = 3'd0; low_w = 3'd0; req = 2'b01;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (pulse !== pat[3-i]) begin
                n_fail++; $display("FAIL zw_pulse[%0d] got=%b exp=%b", i, pulse, pat[3-i]);
            end
            tick();
        end
        n_chk++;
        if (done !== 2'b01) begin n_fail++; $display("FAIL zw_done got=%b exp=01", done); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        burst_len = 4'd1; high_w = 3'd1; low_w = 3'd1; req = 2'b01;
        tick(); tick(); tick();
        n_chk++;
        if (done !== 2'b01) begin n_fail++; $display("FAIL ar_pre_done got=%b exp=01", done); end
        req = 2'b10;
        tick();
        burst_len = 4'd5; high_w = 3'd4; low_w = 3'd2;
        tick();
        n_chk++;
        if (grant !== 2'b10 || pulse !== 1'b1) begin
            n_fail++; $display("FAIL ar_start got g=%b p=%b exp 10/1", grant, pulse);
        end
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if (pulse !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ar_async got p=%b g=%b b=%b exp 0/00/0", pulse, grant, busy);
        end
        tick();
        req = 2'b11;
        #2;
        reset = 1'b0;
        tick();
        n_chk++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL ar_rr_restart got=%b exp=01", grant); end
        req = 2'b00;
        do_reset();
    endtask

    task automatic test_live_config();
        int npulse;
        int cyc;
        do_reset();
        burst_len = 4'd3; high_w = 3'd1; low_w = 3'd1; req = 2'b01;
        tick();
        burst_len = 4'd7; high_w = 3'd5; req = 2'b00;
        npulse = 0;
        cyc    = 0;
        while (done === 2'b00 && cyc < 40) begin
            if (pulse === 1'b1) npulse++;
            tick();
            cyc++;
        end
        n_chk++;
        if (npulse != 3) begin n_fail++; $display("FAIL live_pulses got=%0d exp=3", npulse); end
        n_chk++;
        if (cyc != 6) begin n_fail++; $display("FAIL live_length got=%0d exp=6", cyc); end
        n_chk++;
        if (done !== 2'b01) begin n_fail++; $display("FAIL live_done got=%b exp=01", done); end
        tick();
        n_chk++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL live_idle got g=%b b=%b exp 00/0", grant, busy);
        end
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; burst_len = 4'd0; high_w = 3'd0; low_w = 3'd0;
        test_reset();
        test_basic_burst();
        test_round_robin();
        test_zero_len();
        test_zero_widths();
        test_async_reset();
        test_live_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
